// File: rtl/force_ovr_ctrl_pkg.sv
// Shared types and constants for the force/release override controller.
package force_ovr_pkg;

  // Slot fields are sized for the widest supported configuration. Unused
  // upper bits are always written as zero.
  localparam int MAX_IDX_W = 8;
  localparam int MAX_VAL_W = 32;

  localparam logic [1:0] OP_FORCE   = 2'b01;
  localparam logic [1:0] OP_RELEASE = 2'b10;

  localparam logic [1:0] ST_OK         = 2'b00;
  localparam logic [1:0] ST_FULL       = 2'b01;
  localparam logic [1:0] ST_NOT_FORCED = 2'b10;
  localparam logic [1:0] ST_BAD_NET    = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] net;
    logic [MAX_VAL_W-1:0] value;
  } slot_t;

endpackage

// File: rtl/force_ovr_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at ptr. The pointer
// advances past the winner only when a grant is issued.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic             found;
  int               idx;

  // Search requesters in rotated order from ptr; first valid one wins.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = PTR_W'(idx);
      end
    end
  end

  // Pointer moves to winner+1 (mod NUM_REQ) on accept, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (found)
      ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);
  end

endmodule

// File: rtl/force_ovr_ctrl.sv
// Force/release override controller: arbitrates requester commands into a
// bounded slot table and resolves each net to its forced or driven value.
// Optional: FORCE_OVR_CTRL_RELEASE_ALL_EN adds a release_all input that
// clears every slot and blocks command acceptance for that cycle.
module force_ovr_ctrl
  import force_ovr_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int NUM_NETS  = 8,
  parameter int WIDTH     = 1,
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = 3
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef FORCE_OVR_CTRL_RELEASE_ALL_EN
  input  logic                           release_all,
`endif
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [2*NUM_REQ-1:0]           req_op,
  input  logic [IDX_W*NUM_REQ-1:0]       req_net,
  input  logic [WIDTH*NUM_REQ-1:0]       req_val,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [1:0]                     resp_status,
  input  logic [WIDTH*NUM_NETS-1:0]      drv_in,
  output logic [WIDTH*NUM_NETS-1:0]      net_out,
  output logic [NUM_NETS-1:0]            forced_mask,
  output logic [$clog2(NUM_SLOTS+1)-1:0] free_slots
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int FREE_W = $clog2(NUM_SLOTS + 1);

  slot_t slots [NUM_SLOTS];

  logic                 rel_all;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic [1:0]           sel_op;
  logic [IDX_W-1:0]     sel_net;
  logic [WIDTH-1:0]     sel_val;
  logic [MAX_IDX_W-1:0] net_ext;
  logic                 bad;
  logic                 hit, has_free;
  logic [SLOT_W-1:0]    hit_idx, free_idx;
  logic [FREE_W-1:0]    nfree;
  logic                 wr_en;
  logic [SLOT_W-1:0]    wr_idx;
  slot_t                wr_entry;
  logic [1:0]           status;
  logic [NUM_NETS-1:0][WIDTH-1:0] res;

`ifdef FORCE_OVR_CTRL_RELEASE_ALL_EN
  assign rel_all = release_all;
`else
  assign rel_all = 1'b0;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (!rst && !rel_all),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Mux the winning requester's command fields.
  always_comb begin
    sel_op  = '0;
    sel_net = '0;
    sel_val = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant[r]) begin
        sel_op  = req_op[2*r +: 2];
        sel_net = req_net[IDX_W*r +: IDX_W];
        sel_val = req_val[WIDTH*r +: WIDTH];
      end
    end
  end

  assign net_ext = MAX_IDX_W'(sel_net);
  assign bad     = int'(sel_net) >= NUM_NETS;

  // Table lookup: matching slot, lowest free slot, free count.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    nfree    = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slots[s].valid && slots[s].net == net_ext) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(s);
      end
      if (!slots[s].valid) begin
        if (!has_free) begin
          has_free = 1'b1;
          free_idx = SLOT_W'(s);
        end
        nfree = nfree + FREE_W'(1);
      end
    end
  end

  assign free_slots = nfree;

  // Decode command into a single slot write and a response status. A hit is
  // always rewritten in place so a net never occupies two slots.
  always_comb begin
    status   = ST_OK;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_entry = '0;
    case (sel_op)
      OP_FORCE: begin
        if (bad) begin
          status = ST_BAD_NET;
        end else if (hit || has_free) begin
          wr_en          = 1'b1;
          wr_idx         = hit ? hit_idx : free_idx;
          wr_entry.valid = 1'b1;
          wr_entry.net   = net_ext;
          wr_entry.value = MAX_VAL_W'(sel_val);
        end else begin
          status = ST_FULL;
        end
      end
      OP_RELEASE: begin
        if (bad) begin
          status = ST_BAD_NET;
        end else if (hit) begin
          wr_en  = 1'b1;
          wr_idx = hit_idx;
        end else begin
          status = ST_NOT_FORCED;
        end
      end
      default: status = ST_OK;
    endcase
  end

  // Slot table update; reset and release_all clear every slot.
  always_ff @(posedge clk) begin
    if (rst || rel_all) begin
      for (int s = 0; s < NUM_SLOTS; s++) slots[s] <= '0;
    end else if (accept && wr_en) begin
      slots[wr_idx] <= wr_entry;
    end
  end

  // One-cycle registered response to the accepted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid  <= '0;
      resp_status <= ST_OK;
    end else begin
      resp_valid <= grant;
      if (accept) resp_status <= status;
    end
  end

  // Resolve nets: forced value wins over the continuous driver.
  always_comb begin
    res         = drv_in;
    forced_mask = '0;
    for (int n = 0; n < NUM_NETS; n++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (slots[s].valid && slots[s].net == MAX_IDX_W'(n)) begin
          res[n]         = slots[s].value[WIDTH-1:0];
          forced_mask[n] = 1'b1;
        end
      end
    end
  end

  assign net_out = res;

endmodule
